// File: rtl/shift_add_mul_param_if.sv
// Handshake bundle for shift_add_mul_param.
// master: operand producer / result consumer. slave: the multiplier.
interface shift_add_mul_param_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_data;
  logic [CW-1:0]      out_iters;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_iters, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_data, out_iters, busy
  );
endinterface

// File: rtl/shift_add_mul_param.sv
// Sequential unsigned shift-and-add multiplier, one operation in flight.
// IDLE accepts an operand pair, RUN adds shifted multiplicands one bit of b
// per cycle, DONE holds the product until the consumer takes it.
// Optional build macro MUL_CONST_TIME_EN: always run WIDTH iterations so the
// latency does not depend on operand values; otherwise RUN stops as soon as
// the remaining multiplier bits (or the multiplicand) are zero.
module shift_add_mul_param #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_mul_param_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        cnt_reg;

  // Outputs are registered alongside the state so they track it exactly.
  logic                 in_ready_reg;
  logic                 busy_reg;
  logic                 out_valid_reg;
  logic [2*WIDTH-1:0]   out_data_reg;
  logic [CW-1:0]        out_iters_reg;

  logic                 terminate;
  logic [2*WIDTH-1:0]   addend;

  // Termination test and the shifted multiplicand for this iteration.
  always_comb begin
`ifdef MUL_CONST_TIME_EN
    terminate = (cnt_reg == CW'(WIDTH));
`else
    terminate = (b_reg == '0) || (a_reg == '0);
`endif
    addend = {{WIDTH{1'b0}}, a_reg} << cnt_reg;
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_iters_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.a;
            b_reg        <= bus.b;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          if (terminate) begin
            // The termination cycle does not touch the datapath.
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            out_data_reg  <= acc_reg;
            out_iters_reg <= cnt_reg;
          end else begin
            if (b_reg[0]) begin
              acc_reg <= acc_reg + addend;
            end
            b_reg   <= b_reg >> 1;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // No accept in the handshake cycle; in_ready rises next cycle.
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_iters_reg <= '0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          out_valid_reg <= 1'b0;
          out_data_reg  <= '0;
          out_iters_reg <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_iters = out_iters_reg;

endmodule

// File: doc/shift_add_mul_param.md
SHIFT_ADD_MUL_PARAM -- requirements
Module: shift_add_mul_param

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand width; legal range 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH)+1, SHALL set the iteration counter width; it is derived and SHALL NOT be overridden.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that the operand pair on a/b is valid.
REQ-006 in_ready  output  1  SHALL be high exactly when state is IDLE.
REQ-007 a  input  WIDTH  SHALL be the unsigned multiplicand.
REQ-008 b  input  WIDTH  SHALL be the unsigned multiplier.
REQ-009 out_valid  output  1  SHALL be high exactly when state is DONE.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts out_data.
REQ-011 out_data  output  2*WIDTH  SHALL carry the unsigned product a*b.
REQ-012 out_iters  output  CW  SHALL carry the number of add/shift iterations executed for the current result.
REQ-013 busy  output  1  SHALL be high exactly when state is RUN.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE (one-hot or binary, implementer's choice).
REQ-015 IDLE: on in_valid && in_ready, the block SHALL latch a_reg=a, b_reg=b, acc=0 and cnt=0, then enter RUN.
REQ-016 IDLE: with in_valid low, state SHALL NOT change.
REQ-017 RUN iteration (no terminate): if b_reg[0], acc SHALL become acc + (a_reg << cnt), zero-extended to 2*WIDTH; b_reg SHALL become b_reg >> 1; cnt SHALL become cnt+1.
REQ-018 RUN terminate condition (CONST_TIME_EN undefined): b_reg==0 || a_reg==0, sampled at cycle start; on terminate, enter DONE with no acc/b_reg/cnt update.
REQ-019 Latency from the accept edge to the first out_valid cycle SHALL be 2 + bitlen(b) (bitlen(0)=0), or 2 if a==0.
REQ-020 DONE: out_data SHALL equal acc and out_iters SHALL equal cnt; both SHALL be held stable while out_ready is low.
REQ-021 DONE: on out_ready, the block SHALL enter IDLE next cycle; in_ready SHALL rise in that cycle; no same-cycle accept.
REQ-022 in_valid while not IDLE SHALL be ignored; a/b SHALL NOT be sampled.
REQ-023 Pipeline depth SHALL be 1: a new operation can only be accepted after the previous result is consumed.
REQ-024 acc SHALL never overflow 2*WIDTH bits; no truncation or saturation logic is required.
REQ-025 cnt SHALL never exceed WIDTH.
REQ-026 out_data and out_iters SHALL read 0 outside DONE.

Reset
REQ-027 rst high at a posedge SHALL force state IDLE and zero a_reg, b_reg, acc and cnt, overriding all other inputs.
REQ-028 Output values after reset SHALL be: in_ready=1, out_valid=0, busy=0, out_data=0, out_iters=0.
REQ-029 Reset asserted in RUN or DONE SHALL discard the operation; out_valid SHALL NOT assert for it.
REQ-030 in_valid coincident with rst SHALL be ignored.

Configuration
REQ-031 Macro MUL_CONST_TIME_EN defined: termination SHALL occur only when cnt==WIDTH (WIDTH iterations always run), a_reg/b_reg values SHALL NOT affect control flow, latency SHALL be WIDTH+2 for every operand pair, and out_iters SHALL be WIDTH.
REQ-032 Macro MUL_CONST_TIME_EN undefined: early termination per REQ-018/REQ-019 SHALL apply.
REQ-033 out_data SHALL be identical in both builds for all operands.

Verification (WIDTH=8)
REQ-034 Scenario 1: a=3, b=5, out_ready=1. Without the macro: out_data=15, out_iters=3, out_valid 5 cycles after accept. With the macro: out_iters=8, latency 10.
REQ-035 Scenario 2: operand pairs (a=7, b=0) and (a=0, b=255). Without the macro: out_data=0, latency 2, out_iters=0. With the macro: latency 10.
REQ-036 Scenario 3: a=255, b=255 -> out_data=65025, out_iters=8, latency 10 in both builds.
REQ-037 Scenario 4: out_ready held low 3 cycles in DONE, plus in_valid pulsed during RUN and DONE.
- out_data held stable; in_ready stays 0.
- Pulsed operands not taken.
- IDLE one cycle after the out_ready handshake.
REQ-038 Scenario 5: rst pulsed for 1 cycle in the 3rd RUN cycle of a=9, b=200 -> all outputs at reset values next cycle, no out_valid; a subsequent a=2, b=3 yields 6.
REQ-039 Scenario 6: 1000 random back-to-back operations with random out_ready stalls -> out_data == a*b every transaction, plus a cycle-count check.
- Macro build: a's value SHALL NOT influence latency.
- Non-macro build: latency SHALL equal REQ-019.
